y_scale_rom_reader: RTL and testbench
=====================================

Name: y_scale_rom_reader

Overview:
- Initiator-side companion to the y-scale coefficient ROM.
- On a start pulse it walks a contiguous run of ROM addresses and accounts for the ROM read latency.
- It streams each coefficient, with its line index, on a valid/ready interface to the vertical scaler datapath.
- It absorbs downstream backpressure through a credit-limited skid FIFO, so no ROM read result is ever lost.

Parameters:
- ADDR_WIDTH, 10: ROM address width; must equal the ROM's address width.
- DATA_WIDTH, 32: ROM data width / coefficient width.
- RD_LATENCY, 2: clock edges from the edge that updates rom_addr to the edge at which rom_rd_data is sampled. Legal values 1..4. Use 1 for a ROM without output register, 2 with output register.
- CNT_WIDTH, 11: width of line count / index.
- FIFO_DEPTH, RD_LATENCY+2: skid FIFO entries (localparam, not overridable).

Ports:
- clk, input, 1: single clock for all logic and for the ROM.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse that launches a fetch run; ignored while busy=1.
- cfg_base_addr, input, ADDR_WIDTH: first ROM address; sampled on an accepted start.
- cfg_lines, input, CNT_WIDTH: number of entries to fetch; sampled on an accepted start.
- busy, output, 1: high from the accepted start until the last entry is accepted downstream.
- done, output, 1: one-cycle pulse when a run completes.
- rom_addr, output, ADDR_WIDTH: registered ROM address.
- rom_clk_en, output, 1: ROM clock enable; high in every cycle a read is issued.
- rom_rd_data, input, DATA_WIDTH: ROM read data.
- m_valid, output, 1: coefficient available.
- m_ready, input, 1: downstream accepts when m_valid & m_ready.
- m_data, output, DATA_WIDTH: coefficient.
- m_index, output, CNT_WIDTH: 0-based line index within the run.
- m_last, output, 1: high with the final entry of the run.

Behaviour:
- Reset values (rst_n low, asynchronous): busy=0, done=0, rom_addr=0, rom_clk_en=0, m_valid=0, m_data=0, m_index=0, m_last=0. FIFO is emptied, in-flight pipe is cleared, FSM goes to IDLE.
- Reset mid-run: the run is abandoned. In-flight ROM results are discarded and nothing is emitted after reset releases.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on start when cfg_lines != 0. Latch base and count; busy=1 on the next cycle.
  - IDLE -> IDLE on start when cfg_lines == 0. done pulses for one cycle the following cycle; busy stays 0; no ROM reads.
  - ISSUE -> DRAIN once cfg_lines reads have been issued.
  - DRAIN -> IDLE when the entry with m_last is accepted. done pulses on the following cycle, busy falls with the same edge, and start is accepted again from that cycle.
- Read issue (ISSUE state only):
  - A read is issued when fifo_count + inflight < FIFO_DEPTH, where inflight is the number of reads still in the latency pipe.
  - On issue: rom_addr <= next address, rom_clk_en=1, and a tag (valid, index, last) enters a RD_LATENCY-stage shift pipe.
  - The first issue occurs the cycle after start. Maximum throughput is one read per clock.
- Address arithmetic: next address = base + issued_count, modulo 2^ADDR_WIDTH. Wrap from all-ones to 0 is legal and silent.
- Capture: when the pipe's tail tag is valid, rom_rd_data together with the tag's index/last is written into the FIFO in the same edge. The credit rule guarantees the FIFO is never full at a write.
- Output: m_valid = FIFO not empty. m_data/m_index/m_last come from the FIFO head (first-word-fall-through, registered). A FIFO write and read in the same cycle keep the count unchanged.
- With m_ready held high, the first m_valid appears RD_LATENCY+2 cycles after start; output then sustains one entry per clock.
- start while busy=1 is ignored; cfg is not resampled.
- m_index counts 0..cfg_lines-1, monotonic, with no gaps or duplicates. m_last is high only when m_index == cfg_lines-1.

Test Plan:
- RD_LATENCY=1, ROM content data[a]=a*3. start with base=5, lines=4, m_ready=1 -> m_data 15,18,21,24 with m_index 0..3, m_last on the 4th, one done pulse, busy low afterwards.
- RD_LATENCY=2, base=1022, lines=4, ADDR_WIDTH=10 -> rom_addr sequence 1022,1023,0,1; data order matches the ROM contents at those addresses.
- lines=700, m_ready toggled randomly (50%) -> exactly 700 beats in order, no drop or duplicate, and fifo_count never exceeds FIFO_DEPTH.
- m_ready=0 for 20 cycles after start -> issuing stalls after FIFO_DEPTH reads and m_valid holds with m_index=0. After m_ready=1 the stream resumes gap-free.
- start with lines=0 -> done pulse one cycle later, busy stays 0, rom_clk_en never asserted. A second start pulse while busy during a normal run is ignored.
- Assert rst_n low during DRAIN with 2 entries pending -> all outputs go to reset values immediately. After release, no stale m_valid appears, and a new start runs correctly.

Source files
------------

// File: rtl/y_scale_rom_reader.sv
// rtl/y_scale_rom_reader.sv - y-scale coefficient ROM fetch engine with credit-limited skid FIFO
module y_scale_rom_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_lines,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_clk_en,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  m_index,
  output logic                  m_last
);

  // Enough slots to hold every read in the latency pipe plus two for the output side.
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [CNT_WIDTH-1:0]  lines_q;
  logic [CNT_WIDTH-1:0]  issued;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_last;
  logic [CNT_WIDTH-1:0]  pipe_idx [RD_LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]  fifo_idx  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [FCNT_W-1:0]     fifo_count;

  int   inflight;
  logic issue;
  logic issue_last;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Count reads still travelling through the ROM latency pipe.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (pipe_vld[i]) inflight = inflight + 1;
    end
  end

  // A read is only launched if a FIFO slot is already reserved for its result.
  assign issue      = (state == S_ISSUE) && ((int'(fifo_count) + inflight) < FIFO_DEPTH);
  assign issue_last = (issued == lines_q - 1'b1);
  assign push       = pipe_vld[RD_LATENCY-1];
  assign pop        = m_valid && m_ready;

  assign busy    = (state != S_IDLE);
  assign m_valid = (fifo_count != '0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_index = fifo_idx[rd_ptr];
  assign m_last  = fifo_last[rd_ptr];

  // Run control: latch configuration, walk the address range, finish on the last accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      next_addr <= '0;
      lines_q   <= '0;
      issued    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            next_addr <= cfg_base_addr;
            lines_q   <= cfg_lines;
            issued    <= '0;
            if (cfg_lines != '0) state <= S_ISSUE;
            else                 done  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            next_addr <= next_addr + 1'b1;
            issued    <= issued + 1'b1;
            if (issue_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && m_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered ROM address and clock enable, updated on every issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      rom_clk_en <= 1'b0;
    end else begin
      rom_clk_en <= issue;
      if (issue) rom_addr <= next_addr;
    end
  end

  // Tag pipe mirroring the ROM latency so each result arrives with its index and last flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && issue_last;
      pipe_idx[0]  <= issued;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
      end
    end
  end

  // Skid FIFO: capture ROM data at the pipe tail, present the head first-word-fall-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
      fifo_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= rom_rd_data;
        fifo_idx[wr_ptr]  <= pipe_idx[RD_LATENCY-1];
        fifo_last[wr_ptr] <= pipe_last[RD_LATENCY-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_y_scale_rom_reader.sv
// tb/tb_y_scale_rom_reader.sv - directed self-checking bench for y_scale_rom_reader
module tb_y_scale_rom_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_drv;
  logic        rdy_drv;
  logic        use1;
  logic [9:0]  cfg_base;
  logic [10:0] cfg_lines;

  logic        busy_a, done_a, rom_clk_en_a, m_valid_a, m_last_a;
  logic [9:0]  rom_addr_a;
  logic [31:0] rom_rd_data_a, m_data_a;
  logic [10:0] m_index_a;

  logic        busy_b, done_b, rom_clk_en_b, m_valid_b, m_last_b;
  logic [9:0]  rom_addr_b;
  logic [31:0] rom_rd_data_b, m_data_b;
  logic [10:0] m_index_b;

  logic        busy, done, clk_en, mv, mlast;
  logic [9:0]  raddr;
  logic [31:0] mdata;
  logic [10:0] midx;
  int          fcnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input int a);
    return 32'(a * 3);
  endfunction

  y_scale_rom_reader #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_drv & use1),
    .cfg_base_addr(cfg_base), .cfg_lines(cfg_lines),
    .busy(busy_a), .done(done_a), .rom_addr(rom_addr_a), .rom_clk_en(rom_clk_en_a),
    .rom_rd_data(rom_rd_data_a), .m_valid(m_valid_a), .m_ready(rdy_drv & use1),
    .m_data(m_data_a), .m_index(m_index_a), .m_last(m_last_a)
  );

  y_scale_rom_reader #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_drv & ~use1),
    .cfg_base_addr(cfg_base), .cfg_lines(cfg_lines),
    .busy(busy_b), .done(done_b), .rom_addr(rom_addr_b), .rom_clk_en(rom_clk_en_b),
    .rom_rd_data(rom_rd_data_b), .m_valid(m_valid_b), .m_ready(rdy_drv & ~use1),
    .m_data(m_data_b), .m_index(m_index_b), .m_last(m_last_b)
  );

  // ROM without output register (latency 1) and with output register (latency 2)
  assign rom_rd_data_a = rom_val(int'(rom_addr_a));
  always @(posedge clk) if (rom_clk_en_b) rom_rd_data_b <= rom_val(int'(rom_addr_b));

  assign busy   = use1 ? busy_a       : busy_b;
  assign done   = use1 ? done_a       : done_b;
  assign clk_en = use1 ? rom_clk_en_a : rom_clk_en_b;
  assign raddr  = use1 ? rom_addr_a   : rom_addr_b;
  assign mv     = use1 ? m_valid_a    : m_valid_b;
  assign mdata  = use1 ? m_data_a     : m_data_b;
  assign midx   = use1 ? m_index_a    : m_index_b;
  assign mlast  = use1 ? m_last_a     : m_last_b;
  assign fcnt   = use1 ? int'(dut1.fifo_count) : int'(dut2.fifo_count);

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: ready high, mode 1: random ready; stall: ready low for the first cycles
  task automatic run(input bit sel1, input int base, input int lines, input int mode,
                     input int stall, input bit extra, input string tag);
    int beats = 0, bad = 0, abad = 0, clk_ens = 0, dones = 0;
    int first_v = -1, done_cyc = -1, busy_cnt = 0, gaps = 0, last_acc = -1, max_cnt = 0;
    int lat, depth;
    bit busy1 = 1'b0;
    lat   = sel1 ? 1 : 2;
    depth = lat + 2;
    use1      = sel1;
    cfg_base  = 10'(base);
    cfg_lines = 11'(lines);
    @(negedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      start_drv = (cyc == 0) || (extra && cyc == 3);
      if (extra && cyc == 3) begin
        cfg_base  = 10'(base + 50);
        cfg_lines = 11'(lines + 5);
      end
      rdy_drv = (cyc < stall) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (mv && first_v < 0) first_v = cyc;
      if (busy) busy_cnt++;
      if (cyc == 1) busy1 = busy;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (clk_en) begin
        if (int'(raddr) != ((base + clk_ens) % 1024)) abad++;
        clk_ens++;
      end
      if (fcnt > max_cnt) max_cnt = fcnt;
      if (stall > 0 && cyc == stall - 1) begin
        check({tag, "_stall_reads"}, clk_ens, depth);
        check({tag, "_stall_valid"}, mv, 1);
        check({tag, "_stall_index"}, midx, 0);
      end
      if (mv && rdy_drv) begin
        if (mdata != rom_val((base + beats) % 1024) || int'(midx) != beats ||
            mlast != (beats == lines - 1)) bad++;
        if (last_acc >= 0 && cyc != last_acc + 1) gaps++;
        last_acc = cyc;
        beats++;
      end
      if (dones > 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    start_drv = 1'b0;
    check({tag, "_beats"}, beats, lines);
    check({tag, "_order"}, bad, 0);
    check({tag, "_addr"}, abad, 0);
    check({tag, "_reads"}, clk_ens, lines);
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_fifo_bound"}, max_cnt > depth, 0);
    if (mode != 1) check({tag, "_gaps"}, gaps, 0);
    if (mode == 0 && stall == 0) begin
      check({tag, "_first_valid"}, first_v, (lines == 0) ? -1 : lat + 2);
      check({tag, "_done_cycle"}, done_cyc, (lines == 0) ? 1 : lat + 2 + lines);
      check({tag, "_busy_after_start"}, busy1, lines != 0);
    end
    if (lines == 0) check({tag, "_busy_never"}, busy_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    rst_n     = 1'b0;
    start_drv = 1'b0;
    rdy_drv   = 1'b0;
    use1      = 1'b0;
    cfg_base  = '0;
    cfg_lines = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom_addr", raddr, 0);
    check("rst_rom_clk_en", clk_en, 0);
    check("rst_m_valid", mv, 0);
    check("rst_m_data", mdata, 0);
    check("rst_m_index", midx, 0);
    check("rst_m_last", mlast, 0);
    check("rst_m_valid_lat1", m_valid_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(1'b1, 5,    4,   0, 0,  1'b0, "lat1_basic");
    run(1'b0, 1022, 4,   0, 0,  1'b0, "addr_wrap");
    run(1'b0, 37,   700, 1, 0,  1'b0, "random_ready");
    run(1'b0, 10,   10,  0, 20, 1'b0, "stall");
    run(1'b0, 3,    0,   0, 0,  1'b0, "zero_lines");
    run(1'b0, 60,   3,   0, 0,  1'b1, "restart_ignored");

    // reset in DRAIN with two entries pending
    use1      = 1'b0;
    rdy_drv   = 1'b0;
    cfg_base  = 10'd200;
    cfg_lines = 11'd2;
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("pre_rst_valid", mv, 1);
    check("pre_rst_pending", fcnt, 2);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", mv, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", mdata, 0);
    check("mid_rst_index", midx, 0);
    check("mid_rst_last", mlast, 0);
    check("mid_rst_rom_addr", raddr, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    rdy_drv = 1'b1;
    stale   = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (mv || done || clk_en) stale++;
    end
    check("post_rst_stale", stale, 0);
    run(1'b0, 100, 3, 0, 0, 1'b0, "post_rst_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
